// File: rtl/arb_mux_pkg.sv
// Shared definitions for the round-robin / fixed-priority arbitrating mux.
package arb_mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: first requester searching upward from last+1,
// or from channel 0 in fixed-priority mode.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int LW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [LW-1:0]   last,
  input  arb_mode_e       mode,
  output logic [N_CH-1:0] grant
);

  logic [LW-1:0] start;
  logic [LW-1:0] idx;
  logic          found;

  // Fixed priority reuses the rotating search by pretending the top channel went last.
  assign start = (mode == MODE_FIXED) ? LW'(N_CH - 1) : last;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = LW'((int'(start) + k) % N_CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_rr.sv
// N-channel valid/ready arbitrating mux with a one-beat registered output stage.
module arb_mux_rr
  import arb_mux_pkg::*;
#(
  parameter int        N_CH  = 4,
  parameter int        WIDTH = 4,
  parameter arb_mode_e MODE  = MODE_RR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           in_valid,
  input  logic [N_CH*WIDTH-1:0]     in_data,
  output logic [N_CH-1:0]           in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(N_CH)-1:0]   out_ch,
  input  logic                      out_ready
);

  localparam int CW = $clog2(N_CH);

  logic [CW-1:0]    last;
  logic [N_CH-1:0]  grant;
  logic             load;
  logic             xfer;
  logic [CW-1:0]    sel_ch;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(
    .N_CH (N_CH),
    .LW   (CW)
  ) u_arb (
    .req   (in_valid),
    .last  (last),
    .mode  (MODE),
    .grant (grant)
  );

  assign load     = !out_valid || out_ready;
  assign in_ready = rst_n ? (grant & {N_CH{load}}) : '0;
  assign xfer     = |in_ready;

  // Data steering never feeds control, so X/Z on a data lane passes straight through.
  always_comb begin
    sel_ch   = '0;
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        sel_ch   = CW'(i);
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= CW'(N_CH - 1);
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_ch   <= sel_ch;
        last     <= sel_ch;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Checks a round-robin and a fixed-priority arb_mux_rr side by side against a
// cycle-level behavioural model, with directed scenarios and random traffic.
module tb_arb_mux_rr;
  import arb_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic [3:0]  rdy_rr, rdy_fx;
  logic        ov_rr, ov_fx;
  logic [3:0]  od_rr, od_fx;
  logic [1:0]  och_rr, och_fx;

  int total = 0;
  int bad = 0;

  // model state, index 0 = round-robin instance, 1 = fixed instance
  logic       mv[2];
  logic [3:0] md[2];
  int         mch[2];
  int         mlast[2];

  always #5 clk = ~clk;

  arb_mux_rr #(.N_CH(4), .WIDTH(4), .MODE(MODE_RR)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_ch(och_rr),
    .out_ready(out_ready)
  );

  arb_mux_rr #(.N_CH(4), .WIDTH(4), .MODE(MODE_FIXED)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fx), .out_valid(ov_fx), .out_data(od_fx), .out_ch(och_fx),
    .out_ready(out_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner by the arbitration rules: -1 when nobody is requesting.
  function automatic int pick(input int m, input logic [3:0] v, input int lst);
    if (m == 1) begin
      for (int c = 0; c < 4; c++) if (v[c]) return c;
      return -1;
    end
    for (int k = 1; k <= 4; k++) begin
      if (v[(lst + k) % 4]) return (lst + k) % 4;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; md[m] = 4'h0; mch[m] = 0; mlast[m] = 3;
    end
  endfunction

  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] d, input logic ordy);
    int g[2];
    logic ld[2];
    logic [3:0] exp_rdy;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy;
    #1;
    for (int m = 0; m < 2; m++) begin
      ld[m] = !mv[m] || ordy;
      g[m] = pick(m, v, mlast[m]);
      exp_rdy = (ld[m] && g[m] >= 0) ? (4'b0001 << g[m]) : 4'b0000;
      checkOutput($sformatf("in_ready[m%0d]", m), 32'((m == 0) ? rdy_rr : rdy_fx), 32'(exp_rdy));
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (ld[m]) begin
        if (g[m] >= 0) begin
          mv[m] = 1'b1; md[m] = d[g[m]*4 +: 4]; mch[m] = g[m]; mlast[m] = g[m];
        end else begin
          mv[m] = 1'b0;
        end
      end
      checkOutput($sformatf("out_valid[m%0d]", m), 32'((m == 0) ? ov_rr : ov_fx), 32'(mv[m]));
      checkOutput($sformatf("out_data[m%0d]", m), 32'((m == 0) ? od_rr : od_fx), 32'(md[m]));
      checkOutput($sformatf("out_ch[m%0d]", m), 32'((m == 0) ? och_rr : och_fx), 32'(mch[m]));
    end
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic doReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 4'hF;
    #1;
    checkOutput("rst_out_valid", 32'({ov_rr, ov_fx}), 32'd0);
    checkOutput("rst_out_data", 32'({od_rr, od_fx}), 32'd0);
    checkOutput("rst_out_ch", 32'({och_rr, och_fx}), 32'd0);
    checkOutput("rst_in_ready", 32'({rdy_rr, rdy_fx}), 32'd0);
    modelReset();
    @(negedge clk);
    in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [15:0] ABCD = 16'hDCBA;

  initial begin
    logic [3:0] rr_seq [5];
    rr_seq = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'hF, ABCD, 1'b1);
      checkOutput("rr_seq_data", 32'(od_rr), 32'(rr_seq[i]));
      checkOutput("rr_seq_ch", 32'(och_rr), 32'(i % 4));
      checkOutput("fx_data", 32'(od_fx), 32'hA);
      checkOutput("fx_ready", 32'(rdy_fx), 32'b0001);
    end

    doReset();
    applyStimulus(4'hF, ABCD, 1'b1);
    applyStimulus(4'hF, ABCD, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'hF, ABCD, 1'b0);
      checkOutput("bp_data", 32'(od_rr), 32'hB);
      checkOutput("bp_ch", 32'(och_rr), 32'd1);
      checkOutput("bp_ready", 32'(rdy_rr), 32'd0);
    end
    applyStimulus(4'hF, ABCD, 1'b1);
    checkOutput("bp_release", 32'(od_rr), 32'hC);

    doReset();
    applyStimulus(4'b0100, 16'h0300, 1'b1);
    checkOutput("sparse_data", 32'(od_rr), 32'd3);
    checkOutput("sparse_ch", 32'(och_rr), 32'd2);
    applyStimulus(4'b0001, 16'h0005, 1'b1);
    checkOutput("wrap_ch", 32'(och_rr), 32'd0);

    applyStimulus(4'b1000, 16'hx123, 1'b1);
    checkOutput("x_data", 32'(od_rr), {28'd0, 4'bxxxx});
    checkOutput("x_valid", 32'(ov_rr), 32'd1);
    checkOutput("x_ch", 32'(och_rr), 32'd3);

    // leave a beat stalled, then reset underneath it
    applyStimulus(4'b0010, 16'h0070, 1'b0);
    applyStimulus(4'b0010, 16'h0070, 1'b0);
    doReset();
    applyStimulus(4'b0000, 16'h0000, 1'b1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
